tgl2pls_mc: RTL
===============

# tgl2pls_mc

Parametrised multi-channel toggle-to-pulse converter. Each channel turns every level change on its toggle input into one clean registered pulse of programmable width. Events that arrive while a pulse is in progress are queued in a saturating per-channel backlog counter and replayed, so no event is merged or lost until the backlog overflows. The block sits on the receive side of toggle-based CDC paths and inside single-domain event fabrics. An optional input synchroniser is controlled by a macro.

## Interface
- CHANNELS, 4, number of independent channels (≥1)
- SYNC_STAGES, 2, synchroniser depth when the sync macro is defined (≥2)
- PULSE_LEN, 1, pulse_o high time in clk cycles (≥1)
- PEND_W, 2, backlog counter width; max backlog is 2^PEND_W−1 (≥1)
- Illegal parameter values cause an elaboration error.

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- tgl_i  in  CHANNELS  toggle inputs
- pulse_o  out  CHANNELS  registered pulse outputs
- q_o  out  CHANNELS  registered (synchronised) toggle state
- ovf_o  out  CHANNELS  sticky backlog-overflow flags
- ovf_clr_i  in  CHANNELS  write-1-to-clear for ovf_o

## Operation
- Input stage (per channel):
  - tgl_s = tgl_i after SYNC_STAGES flops if the macro is defined; otherwise tgl_s = tgl_i.
  - q <= tgl_s every cycle.
  - evt = tgl_s ^ q, which is high for exactly one cycle per toggle.
- FSM per channel, with states IDLE, PULSE, GAP:
  - IDLE: if evt, go to PULSE and load len_cnt = PULSE_LEN−1.
  - PULSE: pulse_o = 1. len_cnt decrements each cycle. When len_cnt == 0, go to GAP.
  - GAP: pulse_o = 0 for exactly one cycle. If (pend ≠ 0 or evt), go to PULSE and reload len_cnt. Otherwise go to IDLE.
- Backlog:
  - An evt that is not consumed by a transition to PULSE increments pend.
  - A GAP→PULSE transition consumes from pend first when pend ≠ 0. If evt occurs in the same cycle, pend is unchanged (decrement and increment cancel).
  - An evt when pend is at its maximum and nothing is consumed is dropped, and ovf_o is set.
- ovf_o:
  - Cleared by ovf_clr_i.
  - If set and clear happen in the same cycle, set wins.
- Channels are fully independent; simultaneous events on different channels never interact.
- Pulses have a minimum 1-cycle low gap between them. The maximum sustained rate is one pulse per PULSE_LEN+1 cycles.

## Timing
- Reset values: q, sync flops, pend, len_cnt, pulse_o and ovf_o are all 0; state is IDLE. Reset applies at the first clk edge where rst = 1.
- Reset asserted mid-pulse: pulse_o = 0 from the next cycle, and the backlog is discarded.
- If tgl_i = 1 when reset is released, this counts as one toggle relative to q = 0 and produces one pulse.
- Latency without the macro: if tgl_i changes in cycle N, pulse_o is high in cycles N+1 … N+PULSE_LEN.
- Latency with the macro: add SYNC_STAGES cycles.
- q_o lags tgl_s by 1 cycle.
- ovf_o goes high in the cycle after the dropped event. After ovf_clr_i, ovf_o goes low in the following cycle.

## Configuration
- TGL2PLS_MC_SYNC_EN
  - Defined: SYNC_STAGES-deep flop chain on each tgl_i. Use for asynchronous sources.
  - Undefined: tgl_i must be synchronous to clk, there are no sync flops, and latency is 1 cycle.

## Structure
- Package tgl2pls_pkg holds:
  - the state enum typedef (IDLE, PULSE, GAP);
  - default parameter constants;
  - a helper for the len_cnt width, $clog2(PULSE_LEN+1).
- Sub-module tgl2pls_chan contains one channel's sync, edge detect, FSM, backlog counter and ovf flag. tgl2pls_mc instantiates it CHANNELS times in a generate loop.

## Test plan
All scenarios run without TGL2PLS_MC_SYNC_EN except scenario 6.
1. Basic pulse: PULSE_LEN=1; toggle tgl_i[0] in cycle 10 → pulse_o[0] high in cycle 11 only; other channels stay 0; q_o[0] = 1 from cycle 11.
2. Stretched pulse: PULSE_LEN=3; toggle in cycle 10 → pulse_o high in cycles 11–13, low in cycle 14.
3. Backlog replay: PULSE_LEN=3, PEND_W=2; tgl_i[1] toggles in cycles 10, 11, 12 and 13 → pulses in cycles 11–13, 15–17, 19–21 and 23–25; ovf_o[1] stays 0.
4. Overflow: PULSE_LEN=3, PEND_W=1; toggles in cycles 10, 11 and 12 → pulses in cycles 11–13 and 15–17 only; ovf_o[1] = 1 from cycle 13. Then:
   - ovf_clr_i[1] in cycle 30 → ovf_o[1] = 0 from cycle 31;
   - a clear coinciding with a new overflow leaves ovf_o[1] = 1.
5. Reset mid-operation: rerun scenario 3 with rst high in cycle 16 → pulse_o = 0 from cycle 17, no further pulses, pend = 0 and ovf_o = 0.
6. Synchroniser and simultaneous channels: TGL2PLS_MC_SYNC_EN defined, SYNC_STAGES=3, PULSE_LEN=1; all tgl_i toggle in cycle 10 → every pulse_o bit is high in cycle 14 only.

Source files
------------

// File: rtl/tgl2pls_pkg.sv
// tgl2pls_pkg: shared types and defaults for the multi-channel toggle-to-pulse
// converter (tgl2pls_mc / tgl2pls_chan).
package tgl2pls_pkg;

  // Per-channel pulse sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Default parameter values
  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PULSE_LEN   = 1;
  localparam int DEF_PEND_W      = 2;

  // Width of the pulse-length down-counter; it must hold PULSE_LEN-1.
  function automatic int len_cnt_w(input int pulse_len);
    return (pulse_len < 1) ? 1 : $clog2(pulse_len + 1);
  endfunction

endpackage

// File: rtl/tgl2pls_chan.sv
// tgl2pls_chan: one channel of the toggle-to-pulse converter.
// Optional input synchroniser selected by macro TGL2PLS_MC_SYNC_EN; without it
// tgl_i is used directly and must be synchronous to clk.
module tgl2pls_chan
  import tgl2pls_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PULSE_LEN   = DEF_PULSE_LEN,
  parameter int PEND_W      = DEF_PEND_W
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl_i,
  input  logic ovf_clr_i,
  output logic pulse_o,
  output logic q_o,
  output logic ovf_o
);

  localparam int              LCW      = len_cnt_w(PULSE_LEN);
  localparam logic [LCW-1:0]  LEN_LOAD = LCW'(PULSE_LEN - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // Reject unusable configurations at elaboration time
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("tgl2pls_chan: SYNC_STAGES must be >= 2");
  end
  if (PULSE_LEN < 1) begin : g_bad_len
    $error("tgl2pls_chan: PULSE_LEN must be >= 1");
  end
  if (PEND_W < 1) begin : g_bad_pend
    $error("tgl2pls_chan: PEND_W must be >= 1");
  end

  logic tgl_s;

`ifdef TGL2PLS_MC_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  // Metastability chain for asynchronous toggle sources
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_i};
  end

  assign tgl_s = sync_q[SYNC_STAGES-1];
`else
  assign tgl_s = tgl_i;
`endif

  logic               q_q;
  logic               evt;
  state_e             state_q;
  logic [LCW-1:0]     len_cnt_q;
  logic               pulse_q;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               from_pend;
  logic               start;
  logic               drop;

  // Last seen toggle level; any difference is one event
  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= tgl_s;
  end

  assign evt = tgl_s ^ q_q;

  // Decide whether a pulse starts at this edge and how the backlog moves.
  // A replay from the backlog has priority over a fresh event; when both
  // happen together the backlog count stays put.
  always_comb begin
    from_pend = (state_q == GAP) && (pend_q != '0);
    case (state_q)
      IDLE:    start = evt;
      GAP:     start = from_pend || evt;
      default: start = 1'b0;
    endcase
    pend_d = pend_q;
    drop   = 1'b0;
    if (from_pend) begin
      if (!evt) pend_d = pend_q - PEND_W'(1);
    end else if (evt && !start) begin
      if (pend_q == PEND_MAX) drop = 1'b1;
      else                    pend_d = pend_q + PEND_W'(1);
    end
    ovf_d = drop | (ovf_q & ~ovf_clr_i);
  end

  // Pulse sequencer: IDLE -> PULSE (PULSE_LEN cycles) -> GAP (1 cycle)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= PULSE;
            len_cnt_q <= LEN_LOAD;
            pulse_q   <= 1'b1;
          end
        end
        PULSE: begin
          if (len_cnt_q == '0) begin
            state_q <= GAP;
            pulse_q <= 1'b0;
          end else begin
            len_cnt_q <= len_cnt_q - LCW'(1);
          end
        end
        GAP: begin
          if (start) begin
            state_q   <= PULSE;
            len_cnt_q <= LEN_LOAD;
            pulse_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating backlog counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pulse_o = pulse_q;
  assign q_o     = q_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/tgl2pls_mc.sv
// tgl2pls_mc: multi-channel toggle-to-pulse converter with per-channel event
// backlog and sticky overflow flags. Define TGL2PLS_MC_SYNC_EN to insert a
// SYNC_STAGES-deep synchroniser on every tgl_i bit.
module tgl2pls_mc
  import tgl2pls_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PULSE_LEN   = DEF_PULSE_LEN,
  parameter int PEND_W      = DEF_PEND_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] tgl_i,
  output logic [CHANNELS-1:0] pulse_o,
  output logic [CHANNELS-1:0] q_o,
  output logic [CHANNELS-1:0] ovf_o,
  input  logic [CHANNELS-1:0] ovf_clr_i
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("tgl2pls_mc: CHANNELS must be >= 1");
  end

  // Channels are fully independent copies
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    tgl2pls_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .PULSE_LEN   (PULSE_LEN),
      .PEND_W      (PEND_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .tgl_i     (tgl_i[c]),
      .ovf_clr_i (ovf_clr_i[c]),
      .pulse_o   (pulse_o[c]),
      .q_o       (q_o[c]),
      .ovf_o     (ovf_o[c])
    );
  end

endmodule
